// File: rtl/ic1337_driver.sv
// ic1337_driver: queues A/Q/Z test vectors, applies each to an ic1337 and checks its sampled response
module ic1337_driver #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    vec_in,
  input  logic [2:0]    exp_in,
  input  logic          vec_valid,
  output logic          vec_ready,
  output logic          A0,
  output logic          A1,
  output logic          A2,
  input  logic          Q0,
  input  logic          Q1,
  input  logic          Z,
  output logic          res_valid,
  output logic          res_pass,
  output logic [2:0]    res_got,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t        state_q;
  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [2:0]    a_q, exp_q, got;
  logic          push, pop;

  assign vec_ready  = cnt_q != FULL;
  assign push       = vec_valid && vec_ready;
  assign pop        = state_q == IDLE && cnt_q != '0;
  assign busy       = cnt_q != '0 || state_q != IDLE;
  assign {A2, A1, A0} = a_q;
  assign got        = {Q0, Q1, Z};

  // Occupancy next-state: simultaneous push and pop leave it unchanged
  always_comb begin
    cnt_d = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
  end

  // Vector storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {vec_in, exp_in};
  end

  // FIFO pointers and occupancy, wrapping modulo the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Sequencer: pop and drive, hold A across the ic1337 capture edge, then sample and score
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      exp_q      <= '0;
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      res_got    <= '0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          a_q     <= mem_q[rd_q][5:3];
          exp_q   <= mem_q[rd_q][2:0];
          state_q <= DRIVE;
        end
        DRIVE: state_q <= SAMPLE;
        default: begin
          res_got   <= got;
          res_pass  <= got == exp_q;
          res_valid <= 1'b1;
          if (got == exp_q && pass_count != CMAX) pass_count <= pass_count + 1'b1;
          if (got != exp_q && fail_count != CMAX) fail_count <= fail_count + 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ic1337_driver.sv
// tb_ic1337_driver: randomized scoreboard bench for ic1337_driver with an ic1337 response stand-in
module tb_ic1337_driver;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 0, rst = 1;
  logic [2:0] vec_in = 0, exp_in = 0;
  logic vec_valid = 0;
  logic vec_ready, A0, A1, A2, res_valid, res_pass, busy;
  logic Q0 = 0, Q1 = 0, Z = 0;
  logic [2:0] res_got;
  logic [CW-1:0] pass_count, fail_count;

  ic1337_driver #(.DEPTH(4), .CW(CW)) dut (
    .clk(clk), .rst(rst), .vec_in(vec_in), .exp_in(exp_in), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .A0(A0), .A1(A1), .A2(A2), .Q0(Q0), .Q1(Q1), .Z(Z),
    .res_valid(res_valid), .res_pass(res_pass), .res_got(res_got),
    .pass_count(pass_count), .fail_count(fail_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [2:0] got; logic pass; int pc; int fc;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int res_cyc[$];
  int n_chk = 0, n_fail = 0, cyc = 0, mpc = 0, mfc = 0;
  logic [2:0] rtab [8];
  bit prev_rv = 0, saw_full = 0;

  always @(posedge clk) cyc++;

  // stand-in ic1337: captures A on an edge, presents its response until the next edge
  always @(posedge clk) {Q0, Q1, Z} <= rtab[{A2, A1, A0}];

  function automatic void chk(string nm, longint act, longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // monitor: pops the scoreboard whenever a result is presented
  always @(negedge clk) begin
    if (!vec_ready) saw_full = 1;
    if (!rst && res_valid) begin
      chk("rv_one_cycle", prev_rv, 0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: actual res_valid=1 required none pending (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("res_got", res_got, e.got);
        chk("res_pass", res_pass, e.pass);
        chk("pass_count", pass_count, e.pc);
        chk("fail_count", fail_count, e.fc);
        res_cyc.push_back(cyc);
      end
    end
    prev_rv = res_valid;
  end

  task automatic push(input logic [2:0] v, input logic [2:0] x);
    int b = 0;
    exp_t m;
    @(negedge clk);
    vec_in = v;
    exp_in = x;
    vec_valid = 1;
    while (!vec_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!vec_ready) begin
      chk("push_timeout", 1, 0);
      vec_valid = 0;
      return;
    end
    m.got = rtab[v];
    m.pass = (rtab[v] == x);
    if (m.pass) mpc = (mpc < CMAX) ? mpc + 1 : mpc;
    else mfc = (mfc < CMAX) ? mfc + 1 : mfc;
    m.pc = mpc;
    m.fc = mfc;
    sbq.push_back(m);
    @(posedge clk);
    #1 vec_valid = 0;
  endtask

  task automatic drain();
    int b = 0;
    @(negedge clk);
    vec_valid = 0;
    while ((sbq.size() != 0 || busy) && b < 300) begin
      @(negedge clk);
      b++;
    end
    #1 chk("drain_pending", sbq.size(), 0);
  endtask

  // checks timing after a push into an empty, idle driver (task returns 1 ns after accept edge)
  task automatic latency(input logic [2:0] v);
    @(posedge clk); #1 chk("a_after_1_edge", {A2, A1, A0}, v);
    chk("rv_edge1", res_valid, 0);
    @(posedge clk); #1 chk("rv_edge2", res_valid, 0);
    @(posedge clk); #1 chk("rv_edge3", res_valid, 1);
    @(posedge clk); #1 chk("rv_edge4", res_valid, 0);
  endtask

  task automatic check_reset_state();
    chk("rst_A", {A2, A1, A0}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_got", res_got, 0);
    chk("rst_vec_ready", vec_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pass_count", pass_count, 0);
    chk("rst_fail_count", fail_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1;
    sbq.delete();
    mpc = 0;
    mfc = 0;
    #1 check_reset_state();
    @(negedge clk) rst = 0;
  endtask

  initial begin
    logic [2:0] v;
    for (int i = 0; i < 8; i++) rtab[i] = 3'($urandom);
    #11 check_reset_state();
    #1 rst = 0;
    // single passing vector
    rtab[1] = 3'b010;
    push(3'b001, 3'b010);
    latency(3'b001);
    drain();
    chk("single_pass_count", pass_count, 1);
    // mismatch
    rtab[6] = 3'b001;
    push(3'b110, 3'b111);
    drain();
    chk("mismatch_fail_count", fail_count, 1);
    chk("mismatch_pass_count", pass_count, 1);
    chk("a_holds_last", {A2, A1, A0}, 3'b110);
    // backpressure and ordering
    for (int i = 0; i < 8; i++) rtab[i] = 3'(i) ^ 3'b101;
    saw_full = 0;
    res_cyc.delete();
    for (int i = 0; i < 6; i++) push(3'(i), 3'($urandom));
    drain();
    chk("bp_ready_dropped", saw_full, 1);
    chk("bp_results", res_cyc.size(), 6);
    for (int k = 1; k < res_cyc.size(); k++) chk("bp_spacing", res_cyc[k] - res_cyc[k-1], 3);
    chk("bp_busy_after", busy, 0);
    // reset while the first vector is in SAMPLE and two more are queued
    push(3'b111, 3'b000);
    push(3'b010, 3'b000);
    push(3'b011, 3'b000);
    #1 rst = 1;
    sbq.delete();
    mpc = 0;
    mfc = 0;
    #1 check_reset_state();
    @(negedge clk) rst = 0;
    repeat (6) @(negedge clk);
    chk("post_rst_idle_busy", busy, 0);
    push(3'b100, rtab[4]);
    latency(3'b100);
    drain();
    // randomized traffic
    for (int i = 0; i < 8; i++) rtab[i] = 3'($urandom);
    for (int i = 0; i < 40; i++) begin
      v = 3'($urandom);
      push(v, $urandom_range(0, 1) ? rtab[v] : 3'($urandom));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain();
    // counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) begin
      v = 3'($urandom);
      push(v, rtab[v]);
    end
    drain();
    chk("sat_pass_count", pass_count, CMAX);
    chk("sat_fail_count0", fail_count, 0);
    v = 3'($urandom);
    push(v, ~rtab[v]);
    drain();
    chk("sat_fail_count1", fail_count, 1);
    chk("sat_pass_hold", pass_count, CMAX);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
